// File: rtl/pipe_latch_param.sv
// Parametrised inter-stage pipeline latch for the 5-stage core.
// Carries NCH data channels plus a status flag vector and a valid bit.
// Supports stall (hold), flush (bubble injection) and saturating
// stall/bubble performance counters. All state changes on the falling
// edge of clk, so every output is a plain register output.

// One data channel of the latch. The IR channel (IR=1) is replaced by
// RST_VAL (the NOP) whenever a bubble is loaded; the other channels take
// RST_VAL (zero) only on clr/flush and keep loading data on invalid input.
module pipe_latch_chan #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0,
  parameter bit             IR      = 1'b0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         flush,
  input  logic         stall,
  input  logic         in_valid,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // clr and flush both load the bubble value; stall holds; otherwise load
  always_ff @(negedge clk) begin
    if (clr || flush)  q <= RST_VAL;
    else if (!stall)   q <= (IR && !in_valid) ? RST_VAL : d;
  end

endmodule

module pipe_latch_param #(
  parameter int          DATA_W = 32,
  parameter int          NCH    = 3,
  parameter int          FLAG_W = 1,
  parameter logic [31:0] NOP    = 32'h0000_0000,
  parameter int          CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NCH*DATA_W-1:0] in_data,
  input  logic [FLAG_W-1:0]     in_flags,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [FLAG_W-1:0]     out_flags,
  output logic                  out_valid,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      bubble_cnt
);

  // NOP is specified as 32 bits; only its low DATA_W bits matter.
  localparam logic [DATA_W-1:0] NOP_W   = DATA_W'(NOP);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [FLAG_W-1:0] flags_q;
  logic              valid_q;
  logic              stall_inc;
  logic              bubble_inc;

  // Channel 0 is the instruction register and bubbles to NOP.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    pipe_latch_chan #(
      .W       (DATA_W),
      .RST_VAL ((k == 0) ? NOP_W : {DATA_W{1'b0}}),
      .IR      (k == 0)
    ) u_ch (
      .clk      (clk),
      .clr      (clr),
      .flush    (flush),
      .stall    (stall),
      .in_valid (in_valid),
      .d        (in_data[k*DATA_W +: DATA_W]),
      .q        (out_data[k*DATA_W +: DATA_W])
    );
  end

  // Flags and valid: bubbles carry no flags, stall holds, load takes input
  always_ff @(negedge clk) begin
    if (clr || flush) begin
      flags_q <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      flags_q <= in_valid ? in_flags : '0;
      valid_q <= in_valid;
    end
  end

  // Counter events (clr is handled separately and wins over both).
  // A flush during stall counts as a bubble, not a stall.
  assign stall_inc  = !flush && stall;
  assign bubble_inc = flush || (!stall && !in_valid);

  // Saturating performance counters, cleared only by clr
  always_ff @(negedge clk) begin
    if (clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_inc  && stall_cnt  != CNT_MAX) stall_cnt  <= stall_cnt  + 1'b1;
      if (bubble_inc && bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  // Gate flags with valid so a bubble can never present a flag downstream.
  assign out_flags = flags_q & {FLAG_W{valid_q}};
  assign out_valid = valid_q;

endmodule

// File: tb/tb_pipe_latch_param.sv
// Scoreboard bench for pipe_latch_param: a stimulus process drives inputs
// and pushes the reference model's expected outputs into a queue; a
// monitor process pops and compares them after each falling edge.
module tb_pipe_latch_param;

  localparam int          DATA_W = 32;
  localparam int          NCH    = 3;
  localparam int          FLAG_W = 1;
  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam int          CNT_W  = 4;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  typedef struct {
    logic [NCH*DATA_W-1:0] data;
    logic [FLAG_W-1:0]     flags;
    logic                  valid;
    int                    scnt;
    int                    bcnt;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  clr = 1'b0;
  logic [NCH*DATA_W-1:0] in_data = '0;
  logic [FLAG_W-1:0]     in_flags = '0;
  logic                  in_valid = 1'b0;
  logic                  stall = 1'b0;
  logic                  flush = 1'b0;
  logic [NCH*DATA_W-1:0] out_data;
  logic [FLAG_W-1:0]     out_flags;
  logic                  out_valid;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      bubble_cnt;

  int checks = 0;
  int fails  = 0;
  exp_t sb[$];

  // reference model state, one entry per channel
  logic [DATA_W-1:0] m_ch[NCH];
  logic [FLAG_W-1:0] m_flags;
  logic              m_valid;
  int                m_scnt, m_bcnt;

  pipe_latch_param #(
    .DATA_W(DATA_W), .NCH(NCH), .FLAG_W(FLAG_W), .NOP(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .clr(clr), .in_data(in_data), .in_flags(in_flags),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .out_data(out_data), .out_flags(out_flags), .out_valid(out_valid),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Apply the priority rules (clr > flush > stall > load) to the model.
  task automatic model_edge();
    exp_t e;
    if (clr) begin
      for (int k = 0; k < NCH; k++) m_ch[k] = '0;
      m_ch[0] = NOP[DATA_W-1:0];
      m_flags = '0; m_valid = 1'b0; m_scnt = 0; m_bcnt = 0;
    end else if (flush) begin
      for (int k = 0; k < NCH; k++) m_ch[k] = '0;
      m_ch[0] = NOP[DATA_W-1:0];
      m_flags = '0; m_valid = 1'b0;
      m_bcnt = sat(m_bcnt);
    end else if (stall) begin
      m_scnt = sat(m_scnt);
    end else begin
      for (int k = 0; k < NCH; k++) m_ch[k] = in_data[k*DATA_W +: DATA_W];
      if (in_valid) begin
        m_flags = in_flags; m_valid = 1'b1;
      end else begin
        m_ch[0] = NOP[DATA_W-1:0];
        m_flags = '0; m_valid = 1'b0;
        m_bcnt = sat(m_bcnt);
      end
    end
    for (int k = 0; k < NCH; k++) e.data[k*DATA_W +: DATA_W] = m_ch[k];
    e.flags = m_flags; e.valid = m_valid; e.scnt = m_scnt; e.bcnt = m_bcnt;
    sb.push_back(e);
  endtask

  // Drive one cycle: inputs change 1ns after the rising edge, the DUT
  // captures them on the following falling edge.
  task automatic cyc(input logic c, input logic f, input logic s, input logic v,
                     input logic [NCH*DATA_W-1:0] d, input logic [FLAG_W-1:0] fl);
    @(posedge clk);
    #1;
    clr = c; flush = f; stall = s; in_valid = v; in_data = d; in_flags = fl;
    model_edge();
  endtask

  function automatic logic [NCH*DATA_W-1:0] rnd_data();
    logic [NCH*DATA_W-1:0] d;
    for (int k = 0; k < NCH; k++) d[k*DATA_W +: DATA_W] = $urandom;
    return d;
  endfunction

  // Monitor: each rising edge follows exactly one falling edge, so one
  // expectation is due. It is checked right away and again just before
  // the next falling edge, after the inputs have moved, to catch any
  // combinational path from inputs to outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_data",   out_data,   e.data);
        chk("out_flags",  out_flags,  e.flags);
        chk("out_valid",  out_valid,  e.valid);
        chk("stall_cnt",  stall_cnt,  e.scnt[CNT_W-1:0]);
        chk("bubble_cnt", bubble_cnt, e.bcnt[CNT_W-1:0]);
        #3;
        chk("hold_data",  out_data,   e.data);
        chk("hold_valid", out_valid,  e.valid);
      end
    end
  end

  initial begin
    logic [NCH*DATA_W-1:0] ld;
    int guard;
    ld = {32'hCAFE0003, 32'h00000020, 32'h00A00013};

    // reset with random inputs
    cyc(1, $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1), rnd_data(), 1'b1);
    // load and latency
    cyc(0, 0, 0, 1, ld, 1'b1);
    // stall three edges with changing inputs, then release
    repeat (3) cyc(0, 0, 1, 1, rnd_data(), $urandom_range(0,1));
    cyc(0, 0, 0, 1, rnd_data(), 1'b1);
    // flush overrides stall
    cyc(0, 1, 1, 1, rnd_data(), 1'b1);
    // reload, then bubble on invalid input with flag raised
    cyc(0, 0, 0, 1, ld, 1'b1);
    cyc(0, 0, 0, 0, rnd_data(), 1'b1);
    // stall saturation
    repeat (20) cyc(0, 0, 1, 1, rnd_data(), 1'b1);
    // bubble saturation
    repeat (20) cyc(0, 0, 0, 0, rnd_data(), 1'b1);
    // clr together with flush clears both counters
    cyc(1, 1, 1, 1, rnd_data(), 1'b1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0,99) < 2), ($urandom_range(0,99) < 10),
          ($urandom_range(0,99) < 35), ($urandom_range(0,99) < 70),
          rnd_data(), FLAG_W'($urandom));
    end

    // drain scoreboard with a bounded wait
    guard = 0;
    while (sb.size() != 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #4;
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipe_latch_param.md
Name: pipe_latch_param

Overview:
- Parametrised inter-stage pipeline latch for the 5-stage core; replaces fixed-width, fixed-field stage latches.
- Carries NCH data channels of DATA_W bits and FLAG_W status flags (e.g. overflow), each qualified by a valid bit.
- Adds stall (hold), flush (bubble/NOP injection) and saturating stall/bubble performance counters.
- All state updates on the falling edge of clk, matching the other pipeline latches.

Parameters:
- DATA_W, 32, width of each data channel.
- NCH, 3, number of data channels. Channel 0 is the instruction (IR) channel.
- FLAG_W, 1, width of the status flag vector.
- NOP, 32'h0000_0000, value forced into channel 0 on a bubble or flush. Only the low DATA_W bits are used.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  stage clock; all state updates on its falling edge.
- clr  in  1  synchronous active-high reset; sampled on the clk falling edge.
- in_data  in  NCH*DATA_W  concatenated channels; channel k = bits [k*DATA_W +: DATA_W].
- in_flags  in  FLAG_W  status flags from the upstream stage.
- in_valid  in  1  upstream holds a real instruction.
- stall  in  1  hold current contents.
- flush  in  1  discard: load a bubble.
- out_data  out  NCH*DATA_W  latched channels.
- out_flags  out  FLAG_W  latched flags.
- out_valid  out  1  latched content is a real instruction.
- stall_cnt  out  CNT_W  stall cycles counted.
- bubble_cnt  out  CNT_W  bubbles inserted.

Behaviour:

Priority per falling edge: clr > flush > stall > load.

- **clr=1**
  - out_data: channel 0 = NOP, all other channels = 0.
  - out_flags = 0, out_valid = 0, stall_cnt = 0, bubble_cnt = 0.
  - Applies even mid-stall or mid-flush.
- **flush=1 (clr=0)**
  - Bubble: channel 0 = NOP, other channels = 0, out_flags = 0, out_valid = 0.
  - Overrides a simultaneous stall.
  - bubble_cnt increments; stall_cnt does not.
- **stall=1 (clr=0, flush=0)**
  - out_data, out_flags and out_valid all hold.
  - in_* are ignored.
  - stall_cnt increments.
- **load (clr=0, flush=0, stall=0)**
  - in_valid=1: out_data = in_data, out_flags = in_flags, out_valid = 1.
  - in_valid=0: channels 1..NCH-1 = in_data unchanged, channel 0 = NOP, out_flags = 0, out_valid = 0; bubble_cnt increments.
- **Latency:** one clock (falling edge to outputs). No combinational path from any input to any output.
- **Counters:** saturate at 2^CNT_W-1 and never wrap. Cleared only by clr.
- **Flag gating:** out_flags are forced to 0 whenever out_valid=0, so a bubble can never raise an overflow or exception downstream.
- **NCH=1:** only the IR channel exists; behaviour is otherwise identical.

Test Plan:
- **Reset:** clr=1 for 1 edge with random inputs -> out_data channel0 = 0x00000000 (NOP), out_data channels 1,2 = 0, out_flags = 0, out_valid = 0, stall_cnt = 0, bubble_cnt = 0.
- **Load and latency:** in_valid=1, in_data={0xCAFE0003, 0x00000020, 0x00A00013}, in_flags=1 -> after one falling edge out_data matches, out_flags = 1, out_valid = 1; no output change between edges.
- **Stall:** hold stall=1 for 3 edges while changing in_data -> outputs frozen at the previous values, stall_cnt = 3. Deassert stall -> new in_data loads on the next edge.
- **Flush overrides stall:** stall=1 and flush=1 together -> out_valid = 0, channel0 = NOP, out_flags = 0, bubble_cnt +1, stall_cnt unchanged.
- **Bubble on invalid input:** in_valid=0, in_flags=1 -> out_valid = 0, out_flags = 0, channel0 = NOP, bubble_cnt +1.
- **Saturation and reset priority:** with CNT_W=4, stall for 20 edges -> stall_cnt = 15 and stays there. Then clr=1 together with flush=1 -> both counters = 0.
